// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
// Holds up to eight 8-bit LED patterns and a step period loaded by the CPU over
// an Avalon-MM slave. When enabled, it writes each pattern in turn to the LED
// controller data register over an Avalon-MM master, pausing one period
// between steps. It loops continuously, or stops after one pass in oneshot mode.
module led_pattern_sequencer #(
   parameter logic [2:0] LED_ADDR = 3'd0
) (
   input  logic        csi_clk,
   input  logic        rsi_reset,
   input  logic        avs_s0_chipselect,
   input  logic [3:0]  avs_s0_address,
   input  logic        avs_s0_read,
   input  logic        avs_s0_write,
   input  logic [31:0] avs_s0_writedata,
   output logic [31:0] avs_s0_readdata,
   output logic [2:0]  avm_m0_address,
   output logic        avm_m0_write,
   output logic [31:0] avm_m0_writedata,
   input  logic        avm_m0_waitrequest
);

   localparam logic [3:0] ADDR_CTRL   = 4'd0;
   localparam logic [3:0] ADDR_PERIOD = 4'd1;
   localparam logic [3:0] ADDR_STATUS = 4'd2;
   localparam logic [3:0] ADDR_STEPS  = 4'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // configuration and status registers
   logic        ctrl_enable_reg;
   logic        ctrl_oneshot_reg;
   logic [2:0]  ctrl_last_reg;
   logic [31:0] period_reg;
   logic        done_reg;
   logic [15:0] steps_reg;
   logic [7:0]  pat_reg [0:7];
   logic [7:0]  pat_we;

   // sequencer state
   state_t      state_reg, state_next;
   logic [2:0]  index_reg, index_next;
   logic [31:0] counter_reg, counter_next;
   logic        m_write_reg, m_write_next;
   logic [7:0]  m_pattern_reg, m_pattern_next;

   // handshakes between the CPU side and the sequencer
   logic        cfg_wr;
   logic        cfg_rd;
   logic        ctrl_wr;
   logic        accept;
   logic        done_set;
   logic        enable_clr;
   logic [2:0]  adv_index;
   logic [31:0] period_eff;

   assign cfg_wr  = avs_s0_chipselect & avs_s0_write;
   assign cfg_rd  = avs_s0_chipselect & avs_s0_read;
   assign ctrl_wr = cfg_wr && (avs_s0_address == ADDR_CTRL);

   // A write is accepted on any edge where it is presented and not stalled.
   assign accept = m_write_reg & ~avm_m0_waitrequest;

   // A period of 0 behaves like 1 so every step spends at least one cycle waiting.
   assign period_eff = (period_reg == 32'd0) ? 32'd1 : period_reg;

   // Index wraps when it reaches (or has been left beyond) the last index.
   assign adv_index = (index_reg >= ctrl_last_reg) ? 3'd0 : index_reg + 3'd1;

   assign avm_m0_address   = LED_ADDR;
   assign avm_m0_write     = m_write_reg;
   assign avm_m0_writedata = {24'h0, m_pattern_reg};

   // CTRL and PERIOD registers; a oneshot completion clears enable unless the CPU writes CTRL at the same edge
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         ctrl_enable_reg  <= 1'b0;
         ctrl_oneshot_reg <= 1'b0;
         ctrl_last_reg    <= 3'd0;
         period_reg       <= 32'd0;
      end else begin
         if (ctrl_wr) begin
            ctrl_enable_reg  <= avs_s0_writedata[0];
            ctrl_oneshot_reg <= avs_s0_writedata[1];
            ctrl_last_reg    <= avs_s0_writedata[6:4];
         end else if (enable_clr) begin
            ctrl_enable_reg  <= 1'b0;
         end
         if (cfg_wr && (avs_s0_address == ADDR_PERIOD)) begin
            period_reg <= avs_s0_writedata;
         end
      end
   end

   // done flag: set by oneshot completion, cleared by re-enabling through CTRL
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         done_reg <= 1'b0;
      end else if (ctrl_wr && avs_s0_writedata[0]) begin
         done_reg <= 1'b0;
      end else if (done_set) begin
         done_reg <= 1'b1;
      end
   end

   // STEPS counter of accepted master writes; a CPU clear beats a same-edge accept
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         steps_reg <= 16'd0;
      end else if (cfg_wr && (avs_s0_address == ADDR_STEPS)) begin
         steps_reg <= 16'd0;
      end else if (accept) begin
         steps_reg <= steps_reg + 16'd1;
      end
   end

   // one pattern register per slot at word addresses 8..15
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_pat
         assign pat_we[gi] = cfg_wr && avs_s0_address[3] && (avs_s0_address[2:0] == 3'(gi));

         // pattern slot storage
         always_ff @(posedge csi_clk or posedge rsi_reset) begin
            if (rsi_reset) begin
               pat_reg[gi] <= 8'h00;
            end else if (pat_we[gi]) begin
               pat_reg[gi] <= avs_s0_writedata[7:0];
            end
         end
      end
   endgenerate

   // sequencer state, step index, wait counter and the registered master outputs
   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         state_reg     <= ST_IDLE;
         index_reg     <= 3'd0;
         counter_reg   <= 32'd0;
         m_write_reg   <= 1'b0;
         m_pattern_reg <= 8'h00;
      end else begin
         state_reg     <= state_next;
         index_reg     <= index_next;
         counter_reg   <= counter_next;
         m_write_reg   <= m_write_next;
         m_pattern_reg <= m_pattern_next;
      end
   end

   // next-state logic; the pattern is fetched on entry to WRITE and held until accepted
   always_comb begin
      state_next     = state_reg;
      index_next     = index_reg;
      counter_next   = counter_reg;
      m_write_next   = m_write_reg;
      m_pattern_next = m_pattern_reg;
      done_set       = 1'b0;
      enable_clr     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (ctrl_enable_reg) begin
               index_next     = 3'd0;
               state_next     = ST_WRITE;
               m_write_next   = 1'b1;
               m_pattern_next = pat_reg[0];
            end
         end
         ST_WRITE: begin
            // a disable only takes effect once the pending write has been accepted
            if (accept) begin
               m_write_next = 1'b0;
               counter_next = period_eff - 32'd1;
               state_next   = ctrl_enable_reg ? ST_WAIT : ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!ctrl_enable_reg) begin
               state_next = ST_IDLE;
            end else if (counter_reg == 32'd0) begin
               if (ctrl_oneshot_reg && (index_reg >= ctrl_last_reg)) begin
                  state_next = ST_IDLE;
                  done_set   = 1'b1;
                  enable_clr = 1'b1;
               end else begin
                  index_next     = adv_index;
                  state_next     = ST_WRITE;
                  m_write_next   = 1'b1;
                  m_pattern_next = pat_reg[adv_index];
               end
            end else begin
               counter_next = counter_reg - 32'd1;
            end
         end
         default: begin
            state_next   = ST_IDLE;
            m_write_next = 1'b0;
         end
      endcase
   end

   // config read mux; returns zero unless a read is selected
   always_comb begin
      avs_s0_readdata = 32'd0;
      if (cfg_rd) begin
         if (avs_s0_address[3]) begin
            avs_s0_readdata = {24'h0, pat_reg[avs_s0_address[2:0]]};
         end else begin
            case (avs_s0_address)
               ADDR_CTRL:   avs_s0_readdata = {25'h0, ctrl_last_reg, 2'b00,
                                               ctrl_oneshot_reg, ctrl_enable_reg};
               ADDR_PERIOD: avs_s0_readdata = period_reg;
               ADDR_STATUS: avs_s0_readdata = {23'h0, done_reg, 1'b0, index_reg,
                                               3'b000, (state_reg != ST_IDLE)};
               ADDR_STEPS:  avs_s0_readdata = {16'h0, steps_reg};
               default:     avs_s0_readdata = 32'd0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
// Scoreboard bench: each scenario pushes the patterns it expects to see on the
// master port, and a negedge monitor pops and compares one entry per accepted
// write while recording the cycle at which each write strobe rises.
module tb_led_pattern_sequencer;

   logic        csi_clk = 1'b0;
   logic        rsi_reset;
   logic        avs_s0_chipselect;
   logic [3:0]  avs_s0_address;
   logic        avs_s0_read;
   logic        avs_s0_write;
   logic [31:0] avs_s0_writedata;
   logic [31:0] avs_s0_readdata;
   logic [2:0]  avm_m0_address;
   logic        avm_m0_write;
   logic [31:0] avm_m0_writedata;
   logic        avm_m0_waitrequest;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_count = 0;
   logic prev_write = 1'b0;
   logic [7:0] exp_q[$];
   int rise_q[$];

   led_pattern_sequencer #(.LED_ADDR(3'd0)) dut (
      .csi_clk            (csi_clk),
      .rsi_reset          (rsi_reset),
      .avs_s0_chipselect  (avs_s0_chipselect),
      .avs_s0_address     (avs_s0_address),
      .avs_s0_read        (avs_s0_read),
      .avs_s0_write       (avs_s0_write),
      .avs_s0_writedata   (avs_s0_writedata),
      .avs_s0_readdata    (avs_s0_readdata),
      .avm_m0_address     (avm_m0_address),
      .avm_m0_write       (avm_m0_write),
      .avm_m0_writedata   (avm_m0_writedata),
      .avm_m0_waitrequest (avm_m0_waitrequest)
   );

   always #5 csi_clk = ~csi_clk;

   always @(posedge csi_clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // monitor: an accept is any negedge sample with write high and no stall
   always @(negedge csi_clk) begin
      if (!rsi_reset) begin
         if (avm_m0_write && !prev_write) rise_q.push_back(cyc);
         if (avm_m0_write && !avm_m0_waitrequest) begin
            acc_count++;
            $display("master write %0d: data=0x%02h addr=%0d cycle=%0d",
                     acc_count, avm_m0_writedata[7:0], avm_m0_address, cyc);
            check_value("m_address", 32'(avm_m0_address), 32'h0);
            if (exp_q.size() == 0) begin
               check_value("unexpected_write", 32'(avm_m0_writedata), 32'hFFFF_FFFF);
            end else begin
               check_value("writedata", avm_m0_writedata, {24'h0, exp_q.pop_front()});
            end
         end
      end
      prev_write = avm_m0_write;
   end

   task automatic cpu_write(input logic [3:0] addr, input logic [31:0] data);
      @(posedge csi_clk); #1;
      avs_s0_chipselect = 1'b1;
      avs_s0_write      = 1'b1;
      avs_s0_address    = addr;
      avs_s0_writedata  = data;
      @(posedge csi_clk); #1;
      avs_s0_chipselect = 1'b0;
      avs_s0_write      = 1'b0;
   endtask

   task automatic cpu_read(input logic [3:0] addr, output logic [31:0] data);
      @(posedge csi_clk); #1;
      avs_s0_chipselect = 1'b1;
      avs_s0_read       = 1'b1;
      avs_s0_address    = addr;
      #2 data = avs_s0_readdata;
      avs_s0_chipselect = 1'b0;
      avs_s0_read       = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      cpu_read(addr, d);
      $display("cpu read %s: addr=%0d data=0x%08h", tag, addr, d);
      check_value(tag, d, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge csi_clk);
      #1;
   endtask

   task automatic wait_accepts(input int n, input int budget);
      int k = 0;
      while (acc_count < n && k < budget) begin
         @(posedge csi_clk);
         k++;
      end
      #1;
      if (acc_count < n) check_value("accept_timeout", 32'(acc_count), 32'(n));
   endtask

   task automatic wait_write_high(input int budget);
      int k = 0;
      while (!avm_m0_write && k < budget) begin
         @(posedge csi_clk); #1;
         k++;
      end
      if (!avm_m0_write) check_value("write_timeout", 32'(avm_m0_write), 32'h1);
   endtask

   task automatic check_gaps(input string tag, input int n, input int gap);
      check_value({tag, "_strobes"}, 32'(rise_q.size()), 32'(n));
      for (int i = 1; i < rise_q.size(); i++)
         check_value({tag, "_gap"}, 32'(rise_q[i] - rise_q[i-1]), 32'(gap));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int rises_before;
      rsi_reset          = 1'b1;
      avs_s0_chipselect  = 1'b0;
      avs_s0_address     = 4'd0;
      avs_s0_read        = 1'b0;
      avs_s0_write       = 1'b0;
      avs_s0_writedata   = 32'd0;
      avm_m0_waitrequest = 1'b0;
      repeat (3) @(posedge csi_clk);
      #1 rsi_reset = 1'b0;

      // reset state
      check_value("rst_write", 32'(avm_m0_write), 32'h0);
      check_value("rst_wdata", avm_m0_writedata, 32'h0);
      read_check("rst_ctrl", 4'd0, 32'h0);
      read_check("rst_period", 4'd1, 32'h0);
      read_check("rst_status", 4'd2, 32'h0);
      read_check("rst_steps", 4'd3, 32'h0);

      // read-only and unmapped addresses
      cpu_write(4'd2, 32'hFFFF_FFFF);
      read_check("status_ro", 4'd2, 32'h0);
      cpu_write(4'd5, 32'h1234_5678);
      read_check("unmapped", 4'd5, 32'h0);

      // program patterns; upper bits are dropped
      cpu_write(4'd8, 32'hFFFF_FF01);
      cpu_write(4'd9, 32'h0000_0002);
      cpu_write(4'd10, 32'hABCD_0004);
      read_check("pat0_rb", 4'd8, 32'h01);
      read_check("pat1_rb", 4'd9, 32'h02);
      cpu_write(4'd1, 32'd3);
      read_check("period_rb", 4'd1, 32'd3);

      // continuous loop: 1,2,4,1,2 four cycles apart
      rise_q.delete();
      base = acc_count;
      exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      cpu_write(4'd0, 32'h21);
      check_value("en_latency_pre", 32'(avm_m0_write), 32'h0);
      @(posedge csi_clk); #1;
      check_value("en_latency_post", 32'(avm_m0_write), 32'h1);
      avs_s0_read = 1'b1;
      avs_s0_address = 4'd0;
      #1 check_value("rd_unselected", avs_s0_readdata, 32'h0);
      avs_s0_read = 1'b0;
      wait_accepts(base + 5, 100);
      cpu_write(4'd0, 32'h20);
      idle(8);
      check_gaps("loop", 5, 4);
      read_check("loop_steps", 4'd3, 32'd5);
      read_check("loop_status", 4'd2, 32'h10);
      read_check("loop_ctrl", 4'd0, 32'h20);
      check_value("loop_sb_empty", 32'(exp_q.size()), 32'h0);

      // backpressure: second write stalled for 5 cycles
      cpu_write(4'd3, 32'd0);
      read_check("steps_clear", 4'd3, 32'd0);
      rise_q.delete();
      base = acc_count;
      exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
      cpu_write(4'd0, 32'h21);
      wait_accepts(base + 1, 50);
      wait_write_high(50);
      avm_m0_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge csi_clk); #1;
         check_value("bp_write_held", 32'(avm_m0_write), 32'h1);
         check_value("bp_data_held", avm_m0_writedata, 32'h02);
         if (i == 2) begin
            avs_s0_chipselect = 1'b1;
            avs_s0_read = 1'b1;
            avs_s0_address = 4'd3;
            #1 check_value("bp_steps_mid", avs_s0_readdata, 32'd1);
            avs_s0_chipselect = 1'b0;
            avs_s0_read = 1'b0;
         end
      end
      avm_m0_waitrequest = 1'b0;
      wait_accepts(base + 3, 100);
      cpu_write(4'd0, 32'h20);
      idle(8);
      check_value("bp_strobes", 32'(rise_q.size()), 32'd3);
      if (rise_q.size() == 3) begin
         check_value("bp_gap1", 32'(rise_q[1] - rise_q[0]), 32'd4);
         check_value("bp_gap2", 32'(rise_q[2] - rise_q[1]), 32'd9);
      end
      read_check("bp_steps", 4'd3, 32'd3);

      // oneshot: L=3, PERIOD=0
      cpu_write(4'd11, 32'h08);
      cpu_write(4'd1, 32'd0);
      cpu_write(4'd3, 32'd0);
      rise_q.delete();
      base = acc_count;
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      exp_q.push_back(8'h04); exp_q.push_back(8'h08);
      cpu_write(4'd0, 32'h33);
      wait_accepts(base + 4, 50);
      idle(4);
      check_gaps("os", 4, 2);
      read_check("os_status", 4'd2, 32'h130);
      read_check("os_ctrl", 4'd0, 32'h32);
      read_check("os_steps", 4'd3, 32'd4);

      // disable while a stalled write is pending
      cpu_write(4'd1, 32'd2);
      rise_q.delete();
      base = acc_count;
      avm_m0_waitrequest = 1'b1;
      exp_q.push_back(8'h01);
      cpu_write(4'd0, 32'h11);
      wait_write_high(20);
      read_check("dis_status_busy", 4'd2, 32'h001);
      cpu_write(4'd0, 32'h10);
      for (int i = 0; i < 3; i++) begin
         @(posedge csi_clk); #1;
         check_value("dis_write_held", 32'(avm_m0_write), 32'h1);
         check_value("dis_data_held", avm_m0_writedata, 32'h01);
      end
      avm_m0_waitrequest = 1'b0;
      idle(10);
      check_value("dis_write_low", 32'(avm_m0_write), 32'h0);
      check_value("dis_leds_keep", avm_m0_writedata, 32'h01);
      read_check("dis_status_idle", 4'd2, 32'h0);
      check_value("dis_accepts", 32'(acc_count - base), 32'd1);
      check_value("dis_strobes", 32'(rise_q.size()), 32'd1);

      // live update of L and PAT0 while running
      for (int k = 0; k < 8; k++) cpu_write(4'(8 + k), 32'h10 + 32'(k));
      cpu_write(4'd1, 32'd6);
      cpu_write(4'd3, 32'd0);
      rise_q.delete();
      base = acc_count;
      for (int k = 0; k < 6; k++) exp_q.push_back(8'h10 + 8'(k));
      cpu_write(4'd0, 32'h71);
      wait_accepts(base + 6, 100);
      exp_q.push_back(8'hAA); exp_q.push_back(8'h11); exp_q.push_back(8'hAA);
      cpu_write(4'd0, 32'h11);
      cpu_write(4'd8, 32'hAA);
      wait_accepts(base + 9, 100);
      cpu_write(4'd0, 32'h10);
      idle(10);
      check_gaps("live", 9, 7);
      read_check("live_steps", 4'd3, 32'd9);
      check_value("live_sb_empty", 32'(exp_q.size()), 32'h0);

      // asynchronous reset in the middle of a write
      cpu_write(4'd0, 32'h01);
      wait_write_high(20);
      base = acc_count;
      rises_before = rise_q.size();
      #2 rsi_reset = 1'b1;
      #1;
      check_value("arst_write", 32'(avm_m0_write), 32'h0);
      check_value("arst_wdata", avm_m0_writedata, 32'h0);
      avs_s0_chipselect = 1'b1;
      avs_s0_read = 1'b1;
      avs_s0_address = 4'd2;
      #1 check_value("arst_status", avs_s0_readdata, 32'h0);
      avs_s0_address = 4'd3;
      #1 check_value("arst_steps", avs_s0_readdata, 32'h0);
      avs_s0_address = 4'd0;
      #1 check_value("arst_ctrl", avs_s0_readdata, 32'h0);
      avs_s0_chipselect = 1'b0;
      avs_s0_read = 1'b0;
      @(posedge csi_clk); #1;
      rsi_reset = 1'b0;
      idle(20);
      check_value("arst_no_accepts", 32'(acc_count - base), 32'd0);
      check_value("arst_no_strobes", 32'(rise_q.size() - rises_before), 32'd0);
      check_value("final_sb_empty", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Autonomous pattern engine for the LED peripheral. A CPU loads up to eight 8-bit LED patterns and a step period through an Avalon-MM slave port. Once enabled, the block acts as an Avalon-MM master: it writes each pattern in turn to the LED controller's data register, then waits one period between steps. It sits between the Nios/JTAG master domain and the LED controller slave, so the CPU no longer bit-bangs the LEDs.

## Interface
- LED_ADDR, 3'd0, word address of the LED controller data register driven on avm_m0_address
- csi_clk  in  1  system clock
- rsi_reset  in  1  reset, asynchronous, active-high
- avs_s0_chipselect  in  1  config slave select
- avs_s0_address  in  4  config word address
- avs_s0_read  in  1  config read strobe
- avs_s0_write  in  1  config write strobe
- avs_s0_writedata  in  32  config write data
- avs_s0_readdata  out  32  config read data; combinational, 0 when not (chipselect & read)
- avm_m0_address  out  3  constant LED_ADDR
- avm_m0_write  out  1  master write strobe (registered)
- avm_m0_writedata  out  32  {24'h0, pattern}, registered
- avm_m0_waitrequest  in  1  target stall

## Operation
- Register map (word address):
  - 0 CTRL (R/W): bit0 enable; bit1 oneshot; bits[6:4] last index L (sequence length = L+1).
  - 1 PERIOD (R/W): wait cycles per step. P = max(PERIOD,1).
  - 2 STATUS (RO): bit0 busy (state != IDLE); bits[6:4] current index; bit8 done.
  - 3 STEPS (RO, write clears): 16-bit count of accepted master writes, wraps 0xFFFF->0; bits[31:16] read 0.
  - 8-15 PAT[0..7] (R/W): bits[7:0] stored; upper bits read 0.
  - Reads of addresses 4-7 return 0. Writes to addresses 2 and 4-7 are ignored.
- FSM states: IDLE, WRITE, WAIT.
  - IDLE: when enable=1, load index=0, go to WRITE.
  - WRITE: hold avm_m0_write=1 with writedata={24'h0,PAT[index]} until an edge with waitrequest=0 (accept). Then increment STEPS, load counter=P-1, go to WAIT. Signals never change while waitrequest=1.
  - WAIT: counter decrements each cycle. At counter=0:
    - If enable=0, go to IDLE.
    - Else if oneshot=1 and index>=L: go to IDLE, set done, clear CTRL.enable.
    - Else advance index (index>=L ? 0 : index+1) and go to WRITE.
- Disable (CTRL.enable written to 0):
  - In WRITE, the pending write completes, then the FSM goes to IDLE without waiting out the period.
  - In WAIT, the FSM goes to IDLE on the next edge.
  - The LEDs keep the last written pattern.
- done is cleared by any CTRL write with enable=1.
- PAT, PERIOD and L may change while running. New values apply at the next fetch, reload or advance respectively. If index > new L, the next advance wraps to 0.
- Reset values: all registers, index, counter and STEPS are 0; state is IDLE; avm_m0_write=0; avm_m0_writedata=0; avs_s0_readdata=0.

## Timing
- Enable latency: the CTRL write latches enable at edge N. The FSM enters WRITE at edge N+1, so avm_m0_write is high in the cycle after N+1.
- With waitrequest held 0, write strobes are exactly P+1 cycles apart. Each waitrequest=1 cycle stretches the spacing by one.
- Oneshot total with no stalls: (L+1)*(P+1) cycles from first strobe to busy=0.
- Simultaneous CPU disable and oneshot completion on the same edge: the FSM goes to IDLE and done is set.
- A CPU write to STEPS on the same edge as a master accept: clear wins, STEPS=0.
- Reset asserted mid-transfer: all outputs return to reset values immediately. Dropping an in-flight write is acceptable.

## Test plan
- Reset: assert rsi_reset mid-WRITE -> avm_m0_write=0, STATUS=0, STEPS=0 immediately; no further writes after release.
- Continuous loop: PAT[0..2]=8'h01,8'h02,8'h04; L=2; PERIOD=3; enable; waitrequest=0 -> writedata sequence 1,2,4,1,2 with strobes 4 cycles apart; STEPS=5.
- Backpressure: waitrequest high for 5 cycles on the second write -> write and writedata stable for those 5 cycles; spacing becomes 9 cycles; STEPS increments once.
- Oneshot: L=3, PERIOD=0, oneshot=1 -> exactly 4 writes, 2 cycles apart; then busy=0, done=1, CTRL.enable=0.
- Disable mid-WRITE under waitrequest=1 -> write held until accepted, then IDLE next edge; LEDs keep the last pattern; no further strobes.
- Live update: while running with L=7, write L=1 while index=5 -> the next advance yields index 0; PAT[0] changed to 8'hAA shows on its next fetch.
